// File: rtl/card_game_ctrl.sv
// card_game_ctrl: memory-game sequencer that reveals/compares card pairs and requests redraws.
// Optional draw_done watchdog is compiled in when DRAW_TIMEOUT_EN is defined.
module card_game_ctrl #(
  parameter int unsigned N_CARDS        = 16,
  parameter int unsigned IDX_W          = 4,
  parameter int unsigned VAL_W          = 4,
  parameter int unsigned HOLD_CYCLES    = 40000000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               sel_valid,
  input  logic [IDX_W-1:0]   sel_idx,
  output logic               sel_ready,
  output logic [IDX_W-1:0]   card_addr,
  input  logic [VAL_W-1:0]   card_val,
  output logic [N_CARDS-1:0] face_up,
  output logic [N_CARDS-1:0] matched,
  output logic               draw_do,
  input  logic               draw_done,
  output logic [IDX_W-1:0]   pairs_found,
  output logic [7:0]         move_cnt,
  output logic               game_over,
  output logic               draw_err
);

  localparam int unsigned      HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IDX_W-1:0] PAIRS_ALL = IDX_W'(N_CARDS / 2);
  localparam logic [N_CARDS-1:0] ONE     = N_CARDS'(1);

  typedef enum logic [2:0] {
    S_INIT, S_WAIT_D, S_IDLE, S_RD1, S_PICK2, S_RD2, S_HOLD, S_OVER
  } state_e;

  state_e state_q, state_d;
  state_e ret_q, ret_d;

  logic               draw_do_q, draw_do_d;
  logic [N_CARDS-1:0] face_q, face_d;
  logic [N_CARDS-1:0] matched_q, matched_d;
  logic [IDX_W-1:0]   idx1_q, idx1_d;
  logic [IDX_W-1:0]   idx2_q, idx2_d;
  logic [IDX_W-1:0]   addr_q, addr_d;
  logic [VAL_W-1:0]   val1_q, val1_d;
  logic               pend_match_q, pend_match_d;
  logic [7:0]         move_q, move_d;
  logic [IDX_W-1:0]   pairs_q, pairs_d;
  logic               over_q, over_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic [N_CARDS-1:0] sel_mask, mask1, mask2;
  logic [IDX_W-1:0]   pairs_inc;
  logic               in_range, sel_ok, done_ok, tmo_hit, wait_end, hold_end, last_pair;

  assign sel_mask  = ONE << sel_idx;
  assign mask1     = ONE << idx1_q;
  assign mask2     = ONE << idx2_q;
  assign in_range  = {1'b0, sel_idx} < (IDX_W + 1)'(N_CARDS);
  assign sel_ok    = sel_valid && ((state_q == S_IDLE) || (state_q == S_PICK2)) && in_range
                     && ((sel_mask & (face_q | matched_q)) == '0);
  // draw_done coinciding with our own draw_do pulse belongs to an earlier request
  assign done_ok   = (state_q == S_WAIT_D) && !draw_do_q && draw_done;
  assign wait_end  = done_ok || tmo_hit;
  assign hold_end  = (state_q == S_HOLD) && (hold_q == HOLD_W'(HOLD_CYCLES - 1));
  assign pairs_inc = pairs_q + IDX_W'(1);
  assign last_pair = (pairs_inc == PAIRS_ALL);

`ifdef DRAW_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  assign tmo_hit = (state_q == S_WAIT_D) && !done_ok && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = '0;
    if ((state_q == S_WAIT_D) && !wait_end) tmo_d = tmo_q + TMO_W'(1);
    err_d = err_q | tmo_hit;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign draw_err = err_q;
`else
  assign tmo_hit  = 1'b0;
  assign draw_err = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= S_INIT;
      ret_q   <= S_IDLE;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    unique case (state_q)
      S_INIT: begin
        state_d = S_WAIT_D;
        ret_d   = S_IDLE;
      end
      S_IDLE:   if (sel_ok) state_d = S_RD1;
      S_RD1: begin
        state_d = S_WAIT_D;
        ret_d   = S_PICK2;
      end
      S_PICK2:  if (sel_ok) state_d = S_RD2;
      S_RD2: begin
        state_d = S_WAIT_D;
        ret_d   = (card_val == val1_q) ? S_IDLE : S_HOLD;
      end
      S_WAIT_D: if (wait_end) state_d = (pend_match_q && last_pair) ? S_OVER : ret_q;
      S_HOLD: if (hold_end) begin
        state_d = S_WAIT_D;
        ret_d   = S_IDLE;
      end
      S_OVER:   state_d = S_OVER;
      default:  state_d = S_INIT;
    endcase
  end

  always_comb begin
    sel_ready    = (state_q == S_IDLE) || (state_q == S_PICK2);
    draw_do_d    = 1'b0;
    face_d       = face_q;
    matched_d    = matched_q;
    idx1_d       = idx1_q;
    idx2_d       = idx2_q;
    addr_d       = addr_q;
    val1_d       = val1_q;
    pend_match_d = pend_match_q;
    move_d       = move_q;
    pairs_d      = pairs_q;
    over_d       = over_q;
    hold_d       = '0;
    case (state_q)
      S_INIT: draw_do_d = 1'b1;
      S_IDLE: if (sel_ok) begin
        face_d = face_q | sel_mask;
        idx1_d = sel_idx;
        addr_d = sel_idx;
      end
      S_RD1: begin
        val1_d    = card_val;
        draw_do_d = 1'b1;
      end
      S_PICK2: if (sel_ok) begin
        face_d = face_q | sel_mask;
        idx2_d = sel_idx;
        addr_d = sel_idx;
      end
      S_RD2: begin
        draw_do_d    = 1'b1;
        pend_match_d = (card_val == val1_q);
        if (move_q != '1) move_d = move_q + 8'd1;
      end
      // a match is committed only once the reveal redraw has completed
      S_WAIT_D: if (wait_end) begin
        pend_match_d = 1'b0;
        if (pend_match_q) begin
          matched_d = matched_q | mask1 | mask2;
          pairs_d   = pairs_inc;
          if (last_pair) over_d = 1'b1;
        end
      end
      S_HOLD: begin
        hold_d = hold_end ? '0 : hold_q + HOLD_W'(1);
        if (hold_end) begin
          face_d    = face_q & ~(mask1 | mask2);
          draw_do_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      draw_do_q    <= 1'b0;
      face_q       <= '0;
      matched_q    <= '0;
      idx1_q       <= '0;
      idx2_q       <= '0;
      addr_q       <= '0;
      val1_q       <= '0;
      pend_match_q <= 1'b0;
      move_q       <= '0;
      pairs_q      <= '0;
      over_q       <= 1'b0;
      hold_q       <= '0;
    end else begin
      draw_do_q    <= draw_do_d;
      face_q       <= face_d;
      matched_q    <= matched_d;
      idx1_q       <= idx1_d;
      idx2_q       <= idx2_d;
      addr_q       <= addr_d;
      val1_q       <= val1_d;
      pend_match_q <= pend_match_d;
      move_q       <= move_d;
      pairs_q      <= pairs_d;
      over_q       <= over_d;
      hold_q       <= hold_d;
    end
  end

  assign card_addr   = addr_q;
  assign face_up     = face_q;
  assign matched     = matched_q;
  assign draw_do     = draw_do_q;
  assign pairs_found = pairs_q;
  assign move_cnt    = move_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_card_game_ctrl.sv
// Bench for card_game_ctrl: vector table, directed corner sequences and a random game
// checked against a transaction-level model of the rules. Build with DRAW_TIMEOUT_EN for watchdog test.
module tb_card_game_ctrl;

  localparam int HOLD = 8;

  logic        pclk, rst, sel_valid, sel_ready, draw_do, draw_done, game_over, draw_err;
  logic [4:0]  sel_idx, card_addr, pairs_found;
  logic [3:0]  card_val;
  logic [15:0] face_up, matched;
  logic [7:0]  move_cnt;

  card_game_ctrl #(
    .N_CARDS(16), .IDX_W(5), .VAL_W(4), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(20)
  ) dut (
    .pclk(pclk), .rst(rst), .sel_valid(sel_valid), .sel_idx(sel_idx), .sel_ready(sel_ready),
    .card_addr(card_addr), .card_val(card_val), .face_up(face_up), .matched(matched),
    .draw_do(draw_do), .draw_done(draw_done), .pairs_found(pairs_found), .move_cnt(move_cnt),
    .game_over(game_over), .draw_err(draw_err)
  );

  // card i and card i^1 share a face value
  assign card_val = card_addr[4:1];

  initial pclk = 1'b0;
  initial forever #5 pclk = ~pclk;

  int checks = 0, errors = 0;
  int draws = 0, cyc = 0, done_cyc = 0, last_gap = 0;
  bit done_en = 1, early_mode = 0;

  // draw_cards stand-in: done pulse 5 cycles after each draw_do
  initial begin
    int cnt;
    bit prev_do;
    cnt = 0; prev_do = 0; draw_done = 1'b0;
    forever begin
      @(negedge pclk);
      cyc++;
      draw_done = 1'b0;
      if (rst) begin
        cnt = 0; prev_do = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin draw_done = 1'b1; done_cyc = cyc; end
        end
        if (draw_do) begin
          draws++;
          last_gap = cyc - done_cyc;
          checks++;
          if (prev_do) begin
            errors++;
            $display("FAIL draw_do_width: got high 2 cycles in a row, expected 1-cycle pulse");
          end
          if (done_en) cnt = 5;
          if (early_mode) draw_done = 1'b1;
        end
        prev_do = draw_do;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic settle();
    int n;
    n = 0;
    tick(); tick();
    while (!(sel_ready || game_over) && n < 300) begin tick(); n++; end
    check("settle_ready", {31'd0, sel_ready | game_over}, 32'd1);
  endtask

  task automatic pulse_sel(input int idx);
    sel_idx = idx[4:0];
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    settle();
  endtask

  // ---- rule-level model ----
  logic [15:0] face_m, match_m;
  int pairs_m, moves_m, first_m;
  bit over_m;

  task automatic model_reset();
    face_m = '0; match_m = '0; pairs_m = 0; moves_m = 0; first_m = -1; over_m = 0;
  endtask

  task automatic model_sel(input int idx, output int nd);
    nd = 0;
    if (over_m || idx >= 16) return;
    if (face_m[idx[3:0]] || match_m[idx[3:0]]) return;
    face_m[idx[3:0]] = 1'b1;
    if (first_m < 0) begin
      first_m = idx; nd = 1; return;
    end
    moves_m = (moves_m >= 255) ? 255 : moves_m + 1;
    if ((first_m / 2) == (idx / 2)) begin
      match_m[first_m[3:0]] = 1'b1;
      match_m[idx[3:0]] = 1'b1;
      pairs_m++;
      if (pairs_m == 8) over_m = 1;
      nd = 1;
    end else begin
      face_m[first_m[3:0]] = 1'b0;
      face_m[idx[3:0]] = 1'b0;
      nd = 2;
    end
    first_m = -1;
  endtask

  task automatic apply_sel(input int idx);
    int d0, nd;
    d0 = draws;
    model_sel(idx, nd);
    pulse_sel(idx);
    check("m_face", face_up, face_m);
    check("m_matched", matched, match_m);
    check("m_pairs", pairs_found, pairs_m);
    check("m_moves", move_cnt, moves_m);
    check("m_over", game_over, over_m);
    check("m_ready", sel_ready, !over_m);
    check("m_draws", draws - d0, nd);
    check("m_err", draw_err, 0);
  endtask

  task automatic do_reset();
    int d0;
    rst = 1'b1; sel_valid = 1'b0; sel_idx = '0;
    repeat (3) tick();
    check("rst_face", face_up, 0);
    check("rst_matched", matched, 0);
    check("rst_misc", {pairs_found, move_cnt, card_addr, draw_do, sel_ready, game_over, draw_err}, 0);
    d0 = draws;
    rst = 1'b0;
    model_reset();
    tick();
    check("rst_first_draw", draw_do, 1);
    settle();
    check("rst_ready", sel_ready, 1);
    check("rst_draws", draws - d0, 1);
  endtask

  typedef struct {
    int idx; logic [15:0] face; logic [15:0] mat; int pairs; int moves; int nd; int gap;
  } vec_t;

  initial begin
    vec_t vecs[10];
    int d0, n, idx;

    vecs[0] = '{4,  16'h0010, 16'h0000, 0, 0, 1, 0};
    vecs[1] = '{5,  16'h0030, 16'h0030, 1, 1, 1, 0};
    vecs[2] = '{0,  16'h0031, 16'h0030, 1, 1, 1, 0};
    vecs[3] = '{2,  16'h0030, 16'h0030, 1, 2, 2, HOLD + 1};
    vecs[4] = '{16, 16'h0030, 16'h0030, 1, 2, 0, 0};
    vecs[5] = '{4,  16'h0030, 16'h0030, 1, 2, 0, 0};
    vecs[6] = '{0,  16'h0031, 16'h0030, 1, 2, 1, 0};
    vecs[7] = '{0,  16'h0031, 16'h0030, 1, 2, 0, 0};
    vecs[8] = '{1,  16'h0033, 16'h0033, 2, 3, 1, 0};
    vecs[9] = '{31, 16'h0033, 16'h0033, 2, 3, 0, 0};

    rst = 1'b1; sel_valid = 1'b0; sel_idx = '0;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      d0 = draws;
      pulse_sel(vecs[i].idx);
      check($sformatf("vec%0d_face", i), face_up, vecs[i].face);
      check($sformatf("vec%0d_matched", i), matched, vecs[i].mat);
      check($sformatf("vec%0d_pairs", i), pairs_found, vecs[i].pairs);
      check($sformatf("vec%0d_moves", i), move_cnt, vecs[i].moves);
      check($sformatf("vec%0d_draws", i), draws - d0, vecs[i].nd);
      check($sformatf("vec%0d_ready", i), sel_ready, 1);
      if (vecs[i].gap != 0) check($sformatf("vec%0d_hold_gap", i), last_gap, vecs[i].gap);
    end

    // strobes while the controller is busy are dropped
    d0 = draws;
    sel_idx = 5'd6; sel_valid = 1'b1; tick();
    sel_idx = 5'd7; repeat (4) tick();
    sel_valid = 1'b0;
    settle();
    check("busy_drop_face", face_up, 16'h0073);
    check("busy_drop_draws", draws - d0, 1);
    check("busy_drop_ready", sel_ready, 1);
    pulse_sel(7);
    check("busy_pair_matched", matched, 16'h00F3);
    check("busy_pair_pairs", pairs_found, 3);

    // draw_done coincident with draw_do must not end the wait
    early_mode = 1;
    sel_idx = 5'd8; sel_valid = 1'b1; tick(); sel_valid = 1'b0;
    repeat (3) tick();
    check("early_done_ignored", sel_ready, 0);
    settle();
    pulse_sel(9);
    early_mode = 0;
    check("early_face", face_up, 16'h03F3);
    check("early_pairs", pairs_found, 4);
    check("early_moves", move_cnt, 5);

`ifdef DRAW_TIMEOUT_EN
    done_en = 0;
    sel_idx = 5'd10; sel_valid = 1'b1; tick(); sel_valid = 1'b0;
    n = 0;
    while (!draw_do && n < 10) begin tick(); n++; end
    check("tmo_draw_seen", draw_do, 1);
    repeat (19) tick();
    check("tmo_err_early", draw_err, 0);
    tick();
    check("tmo_err_set", draw_err, 1);
    check("tmo_continues", sel_ready, 1);
    done_en = 1;
    tick();
    check("tmo_err_sticky", draw_err, 1);
`endif

    // random game against the model, then finish it deterministically
    do_reset();
    n = 0;
    while (!over_m && n < 300) begin
      apply_sel($urandom_range(19, 0));
      n++;
    end
    n = 0;
    while (!over_m && n < 40) begin
      if (first_m >= 0) idx = first_m ^ 1;
      else begin
        idx = 0;
        while (match_m[idx[3:0]]) idx++;
      end
      apply_sel(idx);
      n++;
    end
    check("game_over", game_over, 1);
    check("game_pairs", pairs_found, 8);
    for (int k = 0; k < 3; k++) apply_sel($urandom_range(17, 0));

    // move counter saturation through repeated mismatches
    do_reset();
    for (int k = 0; k < 260; k++) begin
      apply_sel(0);
      apply_sel(2);
    end
    check("move_sat", move_cnt, 255);

    // reset in the middle of a mismatch hold
    do_reset();
    pulse_sel(0);
    d0 = draws;
    sel_idx = 5'd2; sel_valid = 1'b1; tick(); sel_valid = 1'b0;
    n = 0;
    while (draws == d0 && n < 10) begin tick(); n++; end
    repeat (10) tick();
    check("hold_face_shown", face_up, 16'h0005);
    check("hold_moves", move_cnt, 1);
    check("hold_ready", sel_ready, 0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
